// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch block: widths, FSM states and
// the layout of one fetched entry.
package cpu_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries. A flush empties
// it in one edge. The head output holds its last shown value while empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int W     = ADDR_W + INSTR_W,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [W-1:0]     last;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? last : mem[rd_ptr];

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the presented head so the output holds once the queue empties.
  always_ff @(posedge clk) begin
    if (rst) last <= '0;
    else     last <= dout;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, drives the combinational instruction
// memory, queues each fetched word with its PC and offers the queue head
// to decode over valid/ready. Redirect flushes and reloads the PC.
module instruction_fetch
#(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(14)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [1:0]         state_o,
  output logic               busy
);
  import cpu_pkg::*;

  localparam int W     = ADDR_W + INSTR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              enq;
  logic              deq;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count_unused;
  logic [W-1:0]      head;

  // A fetch slot exists only in FETCH with room in the queue and no redirect.
  assign enq = (state == FETCH) && !redirect_valid && !fifo_full;
  assign deq = out_valid && out_ready;

  assign imem_addr = pc;
  assign out_valid = !fifo_empty;
  assign out_pc    = head[W-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];
  assign state_o   = state;
  assign busy      = (state == FETCH);

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (enq),
    .pop   (deq),
    .din   ({pc, imem_instr}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  // Fetch FSM and PC: reset, then redirect, then normal sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= IDLE;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      state <= FETCH;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (enq) begin
            if (pc == LAST_PC) state <= DONE;
            else               pc    <= pc + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run,
// all checked against a stream-level model of what decode should receive.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam logic [3:0] LAST = 4'd14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_pc = '0;
  logic [3:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [3:0]  out_pc;
  logic [1:0]  state_o;
  logic        busy;

  logic [15:0] mem [16];
  assign imem_instr = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .state_o        (state_o),
    .busy           (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stream model: which PC decode should see next, and whether more is due.
  bit         m_idle = 1'b1;
  bit         m_more = 1'b0;
  logic [3:0] exp_pc = '0;
  int         deliveries = 0;
  int         cyc = 0;
  int         first_cyc = -1;
  int         last_cyc = -1;

  task automatic cycle(input bit rdy, input bit rv, input logic [3:0] rpc, input bit st);
    fetch_entry_t e;
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    start          = st;
    #1;
    cyc++;
    if (out_valid && out_ready) begin
      if (!m_more) begin
        check("extra_out", 32'(out_valid), 32'd0);
      end else begin
        e.pc    = exp_pc;
        e.instr = mem[exp_pc];
        check("out_pc", 32'(out_pc), 32'(e.pc));
        check("out_instr", 32'(out_instr), 32'(e.instr));
        deliveries++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_pc == LAST) m_more = 1'b0;
        exp_pc = exp_pc + 4'd1;
      end
    end
    if (rv) begin
      exp_pc = rpc;
      m_more = 1'b1;
      m_idle = 1'b0;
    end else if (st && m_idle) begin
      m_idle = 1'b0;
      m_more = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_idle = 1'b1;
    m_more = 1'b0;
    exp_pc = '0;
    deliveries = 0;
    first_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic run_ready(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int c0;
    int d0;

    // Scenario 1: identity memory, free-running drain.
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    c0 = cyc;
    run_ready(20);
    check("t1_count", deliveries, 15);
    check("t1_latency", first_cyc - c0, 2);
    check("t1_span", last_cyc - first_cyc, 14);
    check("t1_state_done", 32'(state_o), 32'd2);
    check("t1_valid_low", 32'(out_valid), 32'd0);

    // Scenario 2: backpressure fills the queue and stalls the PC.
    do_reset();
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_head_instr", 32'(out_instr), 32'd0);
    check("t2_head_pc", 32'(out_pc), 32'd0);
    check("t2_imem_addr", 32'(imem_addr), 32'd2);
    check("t2_busy", 32'(busy), 32'd1);
    run_ready(20);
    check("t2_count", deliveries, 15);

    // Scenario 3: redirect while full at pc=5.
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 20 && imem_addr != 4'd3; i++) cycle(1'b1, 1'b0, 4'd0, 1'b0);
    check("t3_reach_pc3", 32'(imem_addr), 32'd3);
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    check("t3_pc5", 32'(imem_addr), 32'd5);
    check("t3_queued_head", 32'(out_pc), 32'd3);
    cycle(1'b0, 1'b1, 4'd10, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    check("t3_flushed", 32'(out_valid), 32'd0);
    check("t3_new_pc", 32'(imem_addr), 32'd10);
    d0 = deliveries;
    run_ready(20);
    check("t3_count", deliveries - d0, 5);
    check("t3_done", 32'(state_o), 32'd2);

    // Scenario 4: redirect out of DONE.
    cycle(1'b1, 1'b1, 4'd3, 1'b0);
    d0 = deliveries;
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    check("t4_fetch", 32'(state_o), 32'd1);
    run_ready(25);
    check("t4_count", deliveries - d0, 12);
    check("t4_done", 32'(state_o), 32'd2);

    // PC wrap: 15 is not the last address, so it rolls to 0.
    cycle(1'b1, 1'b1, 4'd15, 1'b0);
    d0 = deliveries;
    run_ready(25);
    check("wrap_count", deliveries - d0, 16);

    // Start is ignored once DONE.
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    run_ready(3);
    check("done_ignores_start", 32'(state_o), 32'd2);

    // Scenario 5: reset mid-fetch discards the queue.
    do_reset();
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    check("t5_queued", 32'(out_valid), 32'd1);
    do_reset();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_state", 32'(state_o), 32'd0);
    check("t5_imem_addr", 32'(imem_addr), 32'd0);
    run_ready(5);
    check("t5_stays_idle", 32'(state_o), 32'd0);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    run_ready(20);
    check("t5_count", deliveries, 15);

    // Scenario 6: handshake and redirect on the same edge.
    do_reset();
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 1'b1, 4'd7, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    check("t6_flushed", 32'(out_valid), 32'd0);
    run_ready(20);
    check("t6_count", deliveries, 9);

    // Randomized traffic: random ready, redirects and stray starts.
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 49) == 0);
      check("rnd_busy", 32'(busy), 32'(state_o == 2'd1));
    end
    run_ready(40);
    check("rnd_drained", 32'(m_more), 32'd0);
    check("rnd_done", 32'(state_o), 32'd2);
    check("rnd_valid_low", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Requester side of the 16-entry, 16-bit combinational instruction memory.
- Owns the program counter and drives the memory address. Captures each returned instruction, with its PC, into a small FIFO.
- Presents the FIFO head to the decode stage over a valid/ready handshake.
- Supports start, branch/jump redirect, and automatic stop after a programmable last address.

Parameters:
- ADDR_W, 4, PC and memory address width; the PC wraps modulo 2^ADDR_W.
- INSTR_W, 16, instruction word width.
- DEPTH, 2, fetch FIFO entries (power of 2, at least 2).
- RESET_PC, 0, PC value loaded at reset.
- LAST_PC, 14, final address fetched before entering DONE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE→FETCH.
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  ADDR_W  new PC for a redirect.
- imem_addr  out  ADDR_W  memory address; always equals the pc register.
- imem_instr  in  INSTR_W  memory read data, combinational in imem_addr (same cycle).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  decode accepts the head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  PC of the head instruction.
- state_o  out  2  current state: 0 IDLE, 1 FETCH, 2 DONE.
- busy  out  1  high when state is FETCH.

Behaviour:

Reset, synchronous:
- pc ← RESET_PC; state ← IDLE; FIFO count, read pointer and write pointer ← 0.
- Outputs: out_valid=0, out_instr=0, out_pc=0, busy=0, state_o=0, imem_addr=RESET_PC.
- Reset asserted mid-fetch discards all queued entries on that edge.

State machine:
- IDLE: start=1 → FETCH; pc is unchanged.
- FETCH: a cycle enqueues when count<DEPTH (registered count) and redirect_valid=0.
  - Enqueue writes {pc, imem_instr}.
  - If pc==LAST_PC → DONE with pc held; otherwise pc ← pc+1 mod 2^ADDR_W.
- DONE: no enqueue. The FIFO continues to drain. start is ignored.
- IDLE also ignores nothing but start; start in FETCH or DONE has no effect.

Redirect:
- Takes highest priority after rst, in any state.
- On that edge: FIFO flushed (count=0, so out_valid=0 next cycle); pc ← redirect_pc; state ← FETCH.
- No enqueue happens in the redirect cycle.
- If out_valid & out_ready in the same cycle, the handshake counts as completed for the consumer, then the flush applies.

Dequeue and timing:
- Dequeue happens when out_valid & out_ready; read pointer advances.
- Simultaneous enqueue and dequeue are legal; count is unchanged.
- Latency: an instruction fetched at edge N is visible on out_* after edge N, i.e. 1 cycle.
- With out_ready held high, sustained throughput is 1 instruction/cycle.
- When full with no dequeue, fetch stalls: pc holds and imem_addr is stable.

Output stability:
- While out_valid=1 and out_ready=0, out_instr and out_pc hold.
- out_instr and out_pc are driven from FIFO storage. When the FIFO is empty they hold their last value; on reset they are 0.

Boundary conditions:
- pc=2^ADDR_W−1 (not LAST_PC) wraps to 0.
- redirect_pc==LAST_PC: one instruction is fetched, then DONE.
- Empty FIFO with out_ready=1: no action.
- No combinational path from out_ready to imem_addr.

Decomposition:
- Shared package (cpu_pkg):
  - ADDR_W and INSTR_W constants.
  - State enum with encodings IDLE=2'd0, FETCH=2'd1, DONE=2'd2.
  - Fetch-entry struct {pc, instr}.
- One sub-module: fetch_fifo.
  - Synchronous FIFO of DEPTH entries with flush input.
  - Ports: push, pop, full, empty, count.
- The top level holds the PC register, the FSM and redirect priority.

Test Plan:
1. Memory model with mem[n]=n. After reset, pulse start, out_ready=1 → out_instr/out_pc sequence 0..14 on consecutive cycles; then state_o=2 and out_valid=0.
2. Backpressure: out_ready=0 for 5 cycles after start → FIFO holds 2 entries (instr 0,1), imem_addr stays 2, and head holds at out_instr=0. Release → 0,1,2,… delivered with no loss or duplication.
3. Redirect: while fetching at pc=5 with 2 entries queued, redirect_valid=1 with redirect_pc=10 → next cycle out_valid=0; then deliveries 10,11,… with out_pc matching.
4. Redirect from DONE: redirect_pc=3 → state FETCH; instructions 3..14 delivered, then DONE again.
5. Reset mid-operation: assert rst during FETCH with 2 entries queued → next cycle out_valid=0, state_o=0, imem_addr=0. start is then required to resume from 0.
6. Simultaneous redirect and dequeue: out_valid=1, out_ready=1, redirect_pc=7 in the same cycle → head counted as consumed once; next valid output is instr 7.
